// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// Datapath register file: DEPTH words of N bits, one synchronous write port and
// two independent registered read ports that feed the ALU operands. Word 0 is
// the ISA zero register and always reads as zero. A write and a read to the
// same nonzero address on one edge return the new data (write-to-read bypass),
// so the pipeline never stalls on a back-to-back dependency.
//
// Parameters:
//   N       data word width in bits
//   ADDR_W  address width
//   DEPTH   number of words, must equal 2**ADDR_W
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset, clears memory and read ports
//   we       in   write enable
//   waddr    in   write address (writes to 0 are discarded)
//   wdata    in   write data
//   re_a     in   read enable, port A
//   raddr_a  in   read address, port A
//   re_b     in   read enable, port B
//   raddr_b  in   read address, port B
//   rdata_a  out  registered read data, port A (holds when re_a is low)
//   rdata_b  out  registered read data, port B (holds when re_b is low)
//   valid_a  out  rdata_a was loaded by a read on the previous edge
//   valid_b  out  rdata_b was loaded by a read on the previous edge
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [N-1:0]      rdata_a,
  output logic [N-1:0]      rdata_b,
  output logic              valid_a,
  output logic              valid_b
);

  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_rdata_a;
  logic [N-1:0] r_rdata_b;
  logic         r_valid_a;
  logic         r_valid_b;

  logic         w_wr_en;
  logic [N-1:0] w_rd_a;
  logic [N-1:0] w_rd_b;

  // Writes to the zero register are dropped here, so mem[0] stays at its
  // reset value of 0 forever.
  assign w_wr_en = we && (waddr != '0);

  // Read-value selection: the zero register wins over everything, then a
  // same-edge write to the same address is forwarded, otherwise the stored
  // word. The bypass uses w_wr_en, which already excludes address 0.
  always_comb begin
    w_rd_a = r_mem[raddr_a];
    if (raddr_a == '0) begin
      w_rd_a = '0;
    end else if (w_wr_en && (waddr == raddr_a)) begin
      w_rd_a = wdata;
    end
  end

  always_comb begin
    w_rd_b = r_mem[raddr_b];
    if (raddr_b == '0) begin
      w_rd_b = '0;
    end else if (w_wr_en && (waddr == raddr_b)) begin
      w_rd_b = wdata;
    end
  end

  // Storage array. Reset clears every word so unwritten entries never read X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read ports: data only reloads on an enabled read and holds otherwise;
  // valid is a one-cycle flag marking a fresh load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= re_a;
      r_valid_b <= re_b;
      if (re_a) begin
        r_rdata_a <= w_rd_a;
      end
      if (re_b) begin
        r_rdata_b <= w_rd_b;
      end
    end
  end

  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;
  assign valid_a = r_valid_a;
  assign valid_b = r_valid_b;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2r1w
// Directed bench for reg_file_2r1w: reset behaviour, basic write/read, zero
// register, write-to-read bypass, read-port hold, a full address sweep and an
// asynchronous reset asserted in the middle of a cycle. Expected values are
// hand-computed constants or simple arithmetic on the address.
// -----------------------------------------------------------------------------
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re_a;
  logic [4:0]  raddr_a;
  logic        re_b;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        valid_a;
  logic        valid_b;

  int errorCount;
  int checkCount;

  reg_file_2r1w #(
    .N(32),
    .ADDR_W(5),
    .DEPTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re_a(re_a),
    .raddr_a(raddr_a),
    .re_b(re_b),
    .raddr_b(raddr_b),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b),
    .valid_a(valid_a),
    .valid_b(valid_b)
  );

  // 10-unit clock period; inputs change and outputs are sampled on the
  // falling edge, well away from the rising edge the DUT uses.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one edge worth of inputs, then wait through the rising edge and
  // return at the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic iWe, input logic [4:0] iWaddr,
                               input logic [31:0] iWdata,
                               input logic iReA, input logic [4:0] iRaddrA,
                               input logic iReB, input logic [4:0] iRaddrB);
    we      = iWe;
    waddr   = iWaddr;
    wdata   = iWdata;
    re_a    = iReA;
    raddr_a = iRaddrA;
    re_b    = iReB;
    raddr_b = iRaddrB;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] expA;
    logic [31:0] expB;
    errorCount = 0;
    checkCount = 0;
    rst_n   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    re_a    = 1'b0;
    raddr_a = '0;
    re_b    = 1'b0;
    raddr_b = '0;

    // Reset held for a few cycles, then released on a falling edge.
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata_a", rdata_a, 32'h0);
    checkOutput("reset_valid_a", {31'b0, valid_a}, 32'h0);
    checkOutput("reset_valid_b", {31'b0, valid_b}, 32'h0);
    rst_n = 1'b1;

    // Reads of a freshly reset memory.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd31);
    checkOutput("rst_rd_a0", rdata_a, 32'h0);
    checkOutput("rst_rd_b31", rdata_b, 32'h0);
    checkOutput("rst_valid_a", {31'b0, valid_a}, 32'h1);
    checkOutput("rst_valid_b", {31'b0, valid_b}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd1);
    checkOutput("rst_rd_a1", rdata_a, 32'h0);
    checkOutput("rst_rd_b1", rdata_b, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd0);
    checkOutput("rst_rd_a31", rdata_a, 32'h0);
    checkOutput("rst_rd_b0", rdata_b, 32'h0);

    // Basic write then read.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    checkOutput("wr_only_valid_a", {31'b0, valid_a}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd0);
    checkOutput("basic_rd_a5", rdata_a, 32'hDEADBEEF);
    checkOutput("basic_rd_b0", rdata_b, 32'h0);

    // Zero register ignores writes.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    checkOutput("zero_rd_a", rdata_a, 32'h0);
    checkOutput("zero_rd_b", rdata_b, 32'h0);

    // Bypass: write and both reads on the same edge, then read back.
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
    checkOutput("bypass_a", rdata_a, 32'hA5A5A5A5);
    checkOutput("bypass_b", rdata_b, 32'hA5A5A5A5);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    checkOutput("after_bypass_a", rdata_a, 32'hA5A5A5A5);
    checkOutput("after_bypass_b", rdata_b, 32'hA5A5A5A5);

    // Hold: read addr 5, then disable A while overwriting addr 5.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    checkOutput("hold_first_a", rdata_a, 32'hDEADBEEF);
    checkOutput("hold_first_valid_a", {31'b0, valid_a}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 5'd5, 32'h11111111, 1'b0, 5'd5, 1'b0, 5'd0);
      checkOutput($sformatf("hold_a_%0d", k), rdata_a, 32'hDEADBEEF);
      checkOutput($sformatf("hold_valid_a_%0d", k), {31'b0, valid_a}, 32'h0);
      checkOutput($sformatf("hold_b_%0d", k), rdata_b, 32'hA5A5A5A5);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    checkOutput("hold_reenable_a", rdata_a, 32'h11111111);
    checkOutput("hold_reenable_valid_a", {31'b0, valid_a}, 32'h1);

    // Sweep: fill every nonzero address, then read A ascending, B descending.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 1'b0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      expA = 32'(i) * 32'h01010101;
      expB = 32'(31 - i) * 32'h01010101;
      checkOutput($sformatf("sweep_a_%0d", i), rdata_a, expA);
      checkOutput($sformatf("sweep_b_%0d", 31 - i), rdata_b, expB);
      checkOutput($sformatf("sweep_valid_a_%0d", i), {31'b0, valid_a}, 32'h1);
      checkOutput($sformatf("sweep_valid_b_%0d", i), {31'b0, valid_b}, 32'h1);
    end

    // Asynchronous reset asserted mid-cycle while rdata_a holds a value.
    applyStimulus(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    checkOutput("pre_async_a", rdata_a, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rdata_a", rdata_a, 32'h0);
    checkOutput("async_valid_a", {31'b0, valid_a}, 32'h0);
    checkOutput("async_rdata_b", rdata_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);
    checkOutput("post_async_a9", rdata_a, 32'h0);
    checkOutput("post_async_b5", rdata_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Register file for the datapath: DEPTH words of N bits, one synchronous write port, two registered read ports.
- Feeds ALU operands. Each read port returns data one clock after the address is presented.
- Write-to-read bypass: the pipeline sees a same-cycle write without a stall.
- Word 0 is hardwired to zero, per the ISA zero register.

Parameters:
- N, 32, data word width in bits
- ADDR_W, 5, address width
- DEPTH, 32, number of words; must equal 2**ADDR_W

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  N  write data
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- re_b  input  1  read enable, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_a  output  N  registered read data, port A
- rdata_b  output  N  registered read data, port B
- valid_a  output  1  rdata_a updated by a read on the previous edge
- valid_b  output  1  rdata_b updated by a read on the previous edge

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, asynchronous): all DEPTH words clear to 0. rdata_a and rdata_b go to 0. valid_a and valid_b go to 0. Reset takes effect immediately, not at the next edge.
- Release of rst_n is sampled at clk edges. The first edge with rst_n high may perform a write and reads.
- Write:
  - On a rising edge with we=1 and waddr!=0, mem[waddr] <= wdata.
  - A write to address 0 is discarded; mem[0] always reads 0.
- Read, port A (port B identical, using re_b/raddr_b/rdata_b/valid_b):
  - On a rising edge with re_a=1, rdata_a <= value of word raddr_a and valid_a <= 1. Latency is 1 cycle.
  - The value is selected as follows:
    - raddr_a==0: 0.
    - Otherwise, we=1 and waddr==raddr_a on the same edge (bypass): wdata.
    - Otherwise: mem[raddr_a] before the edge.
  - On a rising edge with re_a=0, rdata_a holds its previous value and valid_a <= 0.
- Ports A and B are independent. Both may read the same address on the same edge and both return the same value.
- A write and two reads to the same nonzero address on one edge: both ports return wdata, and mem holds wdata afterwards.
- Width rules:
  - Addresses are unsigned. Every ADDR_W-bit value is a legal address.
  - No partial writes. wdata is stored with no extension or truncation.
- Reset mid-operation: a write in flight when rst_n falls is lost. The memory reads 0 everywhere after reset.
- There is no X propagation from unwritten words, because reset initialises everything.

Test Plan:
- Reset: hold rst_n=0, then release. Read addresses 0, 1 and 31 on both ports -> rdata=0x00000000 with valid=1 one cycle after each read. Also assert rst_n mid-cycle while rdata_a=0x12345678 -> rdata_a=0 and valid_a=0 immediately, without waiting for a clock edge.
- Basic write/read: write 0xDEADBEEF to addr 5, then next cycle read addr 5 on A and addr 0 on B -> one cycle later rdata_a=0xDEADBEEF, rdata_b=0.
- Zero register: write 0xFFFFFFFF to addr 0, then read addr 0 on both ports -> rdata_a=rdata_b=0.
- Bypass: on a single edge, write 0xA5A5A5A5 to addr 7 while both ports read addr 7 -> after that edge rdata_a=rdata_b=0xA5A5A5A5. Reading addr 7 again a cycle later -> 0xA5A5A5A5.
- Hold: read addr 5 (0xDEADBEEF) on A, then drop re_a for 3 cycles while writing 0x11111111 to addr 5 -> rdata_a stays 0xDEADBEEF and valid_a=0 throughout. Re-enable re_a -> 0x11111111 with valid_a=1.
- Sweep: write i*0x01010101 to every addr i=1..31, then read all addresses back on A ascending and on B descending -> every value matches, addr 0 returns 0, and valid stays high throughout.
